serial_add_ctrl: RTL and testbench
==================================

# serial_add_ctrl

Bit-serial adder/subtractor controller that sequences a single one-bit full-adder cell across a WIDTH-bit operand pair, LSB first, one bit per clock. It sits in the ARITHMETIC group as the low-area alternative to a ripple-carry adder: a requester presents operands with a start pulse, the block owns the full adder and carry flip-flop for WIDTH cycles, then returns the sum with a one-cycle done pulse.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- sub  input  1  1 = A-B; captured on accepted start (see Configuration)
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse, result valid
- sum  output  WIDTH  result, held until next accepted start
- carry_out  output  1  carry out of MSB (for subtraction: 1 = no borrow)
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB

## Operation
- FSM states: IDLE, RUN, DONE. Reset state IDLE.
- IDLE: start=1 -> load opA=a, opB=b XOR {WIDTH{sub_eff}}, carry=sub_eff, bit counter=0, clear result shift register; go RUN. start=0 -> stay.
- RUN: each cycle full adder computes (opA[0], opB[0], carry); sum bit shifted into result MSB, result shifted right; opA/opB shifted right; carry register updated; counter increments. When counter reaches WIDTH-1 the edge also registers carry_out and overflow (carry-in to this bit XOR new carry), and moves to DONE.
- DONE: done=1 for exactly one cycle; unconditionally to IDLE next edge.
- start in RUN or DONE is ignored (not queued).
- sum/carry_out/overflow change only at the final RUN edge; stable in DONE and IDLE thereafter.
- Arithmetic modulo 2^WIDTH; no saturation.

## Timing
- Reset: busy=0, done=0, sum=0, carry_out=0, overflow=0, counter=0, state IDLE; asserting rst_n low mid-RUN aborts immediately to these values.
- Accepting edge = E0. Bit i processed at edge E(i+1). Final bit at edge E(WIDTH); done high during the cycle after E(WIDTH).
- Latency start-to-done: WIDTH+1 cycles. Throughput: one operation per WIDTH+2 cycles (start may be reaccepted the cycle done is low again, i.e. first IDLE cycle).
- busy high from cycle after E0 through cycle of E(WIDTH); done and busy never both high.
- done and busy are decoded from state registers (glitch-free, registered state).

## Configuration
- SERIAL_ADD_SUB_EN defined: sub honoured; sub_eff=sub, B inverted and carry-in forced 1 for two's-complement subtraction.
- Not defined: sub port present but ignored; sub_eff=0, block is add-only, inversion logic not synthesised.

## Structure
- Shared package arith_pkg: FSM state enum (IDLE/RUN/DONE), counter width constant derived as $clog2(WIDTH).
- One sub-module: FULL_ADDER (existing ARITHMETIC cell, ports in0/in1/in2 -> out sum/carry); exactly one instance. All sequencing, shift registers and carry flop live in serial_add_ctrl.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, sub=0 -> after 9 cycles done pulse, sum=0x96, carry_out=0, overflow=1.
- a=0xFF, b=0x01, sub=0 -> sum=0x00, carry_out=1, overflow=0; busy high exactly 8 cycles.
- SERIAL_ADD_SUB_EN defined, a=0x10, b=0x20, sub=1 -> sum=0xF0, carry_out=0, overflow=0; without macro same stimulus -> sum=0x30.
- start pulsed with a=0x01,b=0x01 at cycle 3 of an in-flight 0x5A+0x3C -> ignored; result 0x96, single done pulse.
- rst_n low at RUN cycle 4 -> busy=0, sum=0x00 asynchronously; after release, new start 0x02+0x03 -> sum=0x05.
- Back-to-back: start held high continuously -> done pulses every 10 cycles, each with correct sum.

Source files
------------

// File: rtl/arith_pkg.sv
// ---------------------------------------------------------------------------
// arith_pkg
// Shared definitions for the ARITHMETIC group blocks.
//   state_e   : sequencing FSM states (IDLE / RUN / DONE)
//   cnt_width : bit counter width for a WIDTH-bit serial operation,
//               $clog2(WIDTH) with a floor of one bit
// ---------------------------------------------------------------------------
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // The counter only needs to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// ---------------------------------------------------------------------------
// full_adder
// One-bit full adder cell.
//   in0, in1 : addend bits
//   in2      : carry in
//   sum      : in0 ^ in1 ^ in2
//   carry    : majority(in0, in1, in2)
// ---------------------------------------------------------------------------
module full_adder (
  input  logic in0,
  input  logic in1,
  input  logic in2,
  output logic sum,
  output logic carry
);

  assign sum   = in0 ^ in1 ^ in2;
  assign carry = (in0 & in1) | (in0 & in2) | (in1 & in2);

endmodule

// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl
// Bit-serial adder/subtractor: one full adder cell is stepped across a
// WIDTH-bit operand pair, LSB first, one bit per clock.
//
// Parameters
//   WIDTH      operand/result width, 2..32
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request, sampled only in IDLE
//   a, b       operands, captured on an accepted start
//   sub        1 = A-B, captured on an accepted start
//   busy       high while the operation is running
//   done       one-cycle pulse, result valid
//   sum        result, held until the next result is produced
//   carry_out  carry out of the MSB (subtraction: 1 = no borrow)
//   overflow   signed overflow (carry into MSB ^ carry out of MSB)
//
// Build option
//   SERIAL_ADD_SUB_EN : when defined, sub selects two's-complement
//                       subtraction; otherwise sub is ignored (add only).
// ---------------------------------------------------------------------------
module serial_add_ctrl
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  // Operand B and carry-in as loaded at start.
  logic [WIDTH-1:0] b_load;
  logic             cin_load;

`ifdef SERIAL_ADD_SUB_EN
  // Subtraction is A + ~B + 1.
  assign b_load   = b ^ {WIDTH{sub}};
  assign cin_load = sub;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign b_load     = b;
  assign cin_load   = 1'b0;
`endif

  logic fa_sum;
  logic fa_carry;

  full_adder u_fa (
    .in0   (opa_q[0]),
    .in1   (opb_q[0]),
    .in2   (carry_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          opa_d   = a;
          opb_d   = b_load;
          carry_d = cin_load;
          cnt_d   = '0;
          res_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        // Sum bits enter at the MSB so the LSB lands in bit 0 after WIDTH shifts.
        res_d   = {fa_sum, res_q[WIDTH-1:1]};
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        carry_d = fa_carry;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          // carry_q here is the carry into the MSB.
          sum_d   = {fa_sum, res_q[WIDTH-1:1]};
          cout_d  = fa_carry;
          ovf_d   = carry_q ^ fa_carry;
          cnt_d   = '0;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign sum       = sum_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_add_ctrl
// Self-checking bench for serial_add_ctrl (WIDTH=8). A timeline model
// computes expected busy/done/result from plain integer arithmetic and is
// compared with the DUT on every cycle; directed operations also pin
// hand-computed results, latency and busy length.
// ---------------------------------------------------------------------------
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         overflow;

  int n_checks = 0;
  int n_errors = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic on plain integers.
  function automatic void model_calc(input logic [W-1:0] aa, input logic [W-1:0] bb,
                                     input logic s, output logic [W-1:0] rs,
                                     output logic rc, output logic ro);
    int ua, ub, sa, sb, r;
    ua = int'(aa);
    ub = int'(bb);
    sa = (ua >= (1 << (W-1))) ? ua - (1 << W) : ua;
    sb = (ub >= (1 << (W-1))) ? ub - (1 << W) : ub;
    if (s) begin
      r  = sa - sb;
      rc = (ua >= ub);
      rs = W'(ua - ub);
    end else begin
      r  = sa + sb;
      rc = ((ua + ub) >= (1 << W));
      rs = W'(ua + ub);
    end
    ro = (r > (1 << (W-1)) - 1) || (r < -(1 << (W-1)));
  endfunction

  // Timeline model: phase 0 = idle, 1..W = running, W+1 = done cycle.
  int           m_phase;
  logic [W-1:0] m_sum, p_sum;
  logic         m_c, m_o, p_c, p_o;
  logic         m_sub;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_sum   = '0;
      m_c     = 1'b0;
      m_o     = 1'b0;
    end else if (m_phase == 0) begin
      if (start) begin
`ifdef SERIAL_ADD_SUB_EN
        m_sub = sub;
`else
        m_sub = 1'b0;
`endif
        model_calc(a, b, m_sub, p_sum, p_c, p_o);
        m_phase = 1;
      end
    end else if (m_phase == W) begin
      m_sum   = p_sum;
      m_c     = p_c;
      m_o     = p_o;
      m_phase = W + 1;
    end else if (m_phase == W + 1) begin
      m_phase = 0;
    end else begin
      m_phase++;
    end
  end

  // Cycle-by-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", busy, (m_phase >= 1 && m_phase <= W));
      chk("done", done, (m_phase == W + 1));
      chk("sum", sum, m_sum);
      chk("carry_out", carry_out, m_c);
      chk("overflow", overflow, m_o);
    end
  end

  // Start one operation from IDLE and check it against literals.
  // inj > 0 pulses a stray start (0x01+0x01) at that in-flight cycle.
  task automatic run_op(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic s,
                        input logic [W-1:0] es, input logic ec, input logic eo,
                        input int inj, input string nm);
    int k;
    int busy_cnt;
    bit seen;
    @(negedge clk);
    start = 1'b1; a = aa; b = bb; sub = s;
    @(negedge clk);
    start = 1'b0;
    k = 1; busy_cnt = 0; seen = 1'b0;
    while (!seen && k <= 20) begin
      if (busy) busy_cnt++;
      if (done) seen = 1'b1;
      else begin
        if (k == inj) begin
          start = 1'b1; a = 8'h01; b = 8'h01;
        end
        @(negedge clk);
        start = 1'b0;
        k++;
      end
    end
    chk({nm, " done_seen"}, 32'(seen), 1);
    chk({nm, " latency"}, k, W + 1);
    chk({nm, " busy_cycles"}, busy_cnt, W);
    chk({nm, " sum"}, sum, es);
    chk({nm, " carry_out"}, carry_out, ec);
    chk({nm, " overflow"}, overflow, eo);
    @(negedge clk);
    chk({nm, " single_done"}, done, 0);
    $display("op %s: a=%h b=%h sub=%0d -> sum=%h c=%0d v=%0d", nm, aa, bb, s, sum, carry_out, overflow);
  endtask

  initial begin
    int last_done;
    int cyc;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; sub = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset sum", sum, 0);
    chk("reset carry_out", carry_out, 0);
    chk("reset overflow", overflow, 0);
    #1 rst_n = 1'b1;

    run_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 0, "add_5a_3c");
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0, "add_ff_01");
`ifdef SERIAL_ADD_SUB_EN
    run_op(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, 0, "sub_10_20");
`else
    run_op(8'h10, 8'h20, 1'b1, 8'h30, 1'b0, 1'b0, 0, "sub_ignored_10_20");
`endif
    run_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 3, "ignore_start");

    // Reset in the middle of RUN.
    @(negedge clk);
    start = 1'b1; a = 8'h5A; b = 8'h3C; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort busy", busy, 0);
    chk("abort sum", sum, 0);
    chk("abort done", done, 0);
    $display("abort: busy=%0d sum=%h", busy, sum);
    @(negedge clk);
    #1 rst_n = 1'b1;
    run_op(8'h02, 8'h03, 1'b0, 8'h05, 1'b0, 1'b0, 0, "after_reset");

    // Back-to-back with start held high.
    last_done = -1;
    cyc = 0;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 45; i++) begin
      a = W'($urandom); b = W'($urandom); sub = 1'(($urandom));
      @(negedge clk);
      cyc++;
      if (done) begin
        if (last_done >= 0) chk("b2b spacing", cyc - last_done, W + 2);
        $display("b2b done at cycle %0d sum=%h", cyc, sum);
        last_done = cyc;
      end
    end
    start = 1'b0;
    chk("b2b pulses seen", 32'(last_done >= 0), 1);
    repeat (W + 3) @(negedge clk);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      start = ($urandom_range(0, 3) == 0);
      a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
      @(negedge clk);
      if (done) $display("rand done: sum=%h c=%0d v=%0d", sum, carry_out, overflow);
    end
    start = 1'b0;
    repeat (W + 3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
